wfg_wb_initiator: RTL and testbench

Single-outstanding Wishbone classic initiator that turns a valid/ready command stream into bus cycles toward the waveform-generator register slaves (wfg_core_top and peers). It sits between a host-side command source (test sequencer, UART/SPI bridge, or on-chip controller) and the Wishbone bus. It returns read data or a timeout error on a valid/ready response channel.

---
 rtl/wfg_wb_initiator_if.sv | 34 +++
 rtl/wfg_wb_initiator.sv | 87 ++++++++
 tb/tb_wfg_wb_initiator.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/wfg_wb_initiator_if.sv
// wfg_wb_initiator_if: command, response and Wishbone signals of the initiator
interface wfg_wb_initiator_if #(
  parameter int BUSW = 32
);
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic            cmd_we_i;
  logic [BUSW-1:0] cmd_adr_i;
  logic [BUSW-1:0] cmd_dat_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [BUSW-1:0] rsp_dat_o;
  logic            rsp_err_o;
  logic            wbm_cyc_o;
  logic            wbm_stb_o;
  logic            wbm_we_o;
  logic [3:0]      wbm_sel_o;
  logic [BUSW-1:0] wbm_adr_o;
  logic [BUSW-1:0] wbm_dat_o;
  logic [BUSW-1:0] wbm_dat_i;
  logic            wbm_ack_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i, wbm_dat_i, wbm_ack_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i, wbm_dat_i, wbm_ack_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wfg_wb_initiator.sv
// wfg_wb_initiator: single-outstanding Wishbone classic initiator with timeout
module wfg_wb_initiator #(
  parameter int BUSW    = 32,
  parameter int TIMEOUT = 16
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_ni,
  wfg_wb_initiator_if.master  bus_if
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [BUSW-1:0] adr_q, adr_d;
  logic [BUSW-1:0] dat_q, dat_d;
  logic [BUSW-1:0] rdat_q, rdat_d;
  logic            err_q, err_d;

  // Handshake/bus strobes decode from state only, so reset drops cyc/stb at once
  assign bus_if.cmd_ready_o = state_q == IDLE;
  assign bus_if.rsp_valid_o = state_q == RESP;
  assign bus_if.wbm_cyc_o   = state_q == BUS;
  assign bus_if.wbm_stb_o   = state_q == BUS;
  assign bus_if.wbm_we_o    = we_q;
  assign bus_if.wbm_sel_o   = 4'b1111;
  assign bus_if.wbm_adr_o   = adr_q;
  assign bus_if.wbm_dat_o   = dat_q;
  assign bus_if.rsp_dat_o   = rdat_q;
  assign bus_if.rsp_err_o   = err_q;

  // Next state: accept command, run bus cycle (ack beats timeout), hold response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus_if.cmd_valid_i) begin
        we_d    = bus_if.cmd_we_i;
        adr_d   = bus_if.cmd_adr_i;
        dat_d   = bus_if.cmd_dat_i;
        cnt_d   = '0;
        state_d = BUS;
      end
      BUS: if (bus_if.wbm_ack_i) begin
        rdat_d  = we_q ? '0 : bus_if.wbm_dat_i;
        err_d   = 1'b0;
        state_d = RESP;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        rdat_d  = '0;
        err_d   = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP: if (bus_if.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_wfg_wb_initiator.sv
// tb_wfg_wb_initiator: directed self-checking bench for wfg_wb_initiator
module tb_wfg_wb_initiator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   n;

  always #5 clk = ~clk;

  wfg_wb_initiator_if #(.BUSW(32)) bus_if ();

  wfg_wb_initiator #(.BUSW(32), .TIMEOUT(16)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus_if    (bus_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    bus_if.cmd_valid_i = 1'b1;
    bus_if.cmd_we_i    = we;
    bus_if.cmd_adr_i   = adr;
    bus_if.cmd_dat_i   = dat;
  endtask

  initial begin
    bus_if.cmd_valid_i = 1'b0;
    bus_if.cmd_we_i    = 1'b0;
    bus_if.cmd_adr_i   = '0;
    bus_if.cmd_dat_i   = '0;
    bus_if.rsp_ready_i = 1'b0;
    bus_if.wbm_dat_i   = '0;
    bus_if.wbm_ack_i   = 1'b0;
    repeat (3) tick();
    chk1("rst_cmd_ready", bus_if.cmd_ready_o, 1'b1);
    chk1("rst_rsp_valid", bus_if.rsp_valid_o, 1'b0);
    chk1("rst_cyc", bus_if.wbm_cyc_o, 1'b0);
    chk1("rst_stb", bus_if.wbm_stb_o, 1'b0);
    chk1("rst_we", bus_if.wbm_we_o, 1'b0);
    chk32("rst_adr", bus_if.wbm_adr_o, 32'h0);
    chk32("rst_dat", bus_if.wbm_dat_o, 32'h0);
    chk32("rst_rsp_dat", bus_if.rsp_dat_o, 32'h0);
    chk1("rst_rsp_err", bus_if.rsp_err_o, 1'b0);
    chk32("rst_sel", {28'h0, bus_if.wbm_sel_o}, 32'hF);
    rst_n = 1'b1;
    tick();

    // Write, ack one cycle after stb
    cmd(1'b1, 32'h04, 32'hA5A5_0001);
    tick();
    bus_if.cmd_valid_i = 1'b0;
    chk1("wr_cyc", bus_if.wbm_cyc_o, 1'b1);
    chk1("wr_stb", bus_if.wbm_stb_o, 1'b1);
    chk1("wr_we", bus_if.wbm_we_o, 1'b1);
    chk32("wr_adr", bus_if.wbm_adr_o, 32'h04);
    chk32("wr_dat", bus_if.wbm_dat_o, 32'hA5A5_0001);
    chk1("wr_cmd_ready", bus_if.cmd_ready_o, 1'b0);
    tick();
    chk1("wr_cyc_hold", bus_if.wbm_cyc_o, 1'b1);
    chk1("wr_no_rsp_yet", bus_if.rsp_valid_o, 1'b0);
    bus_if.wbm_ack_i = 1'b1;
    bus_if.wbm_dat_i = 32'hDEAD_BEEF;
    tick();
    bus_if.wbm_ack_i = 1'b0;
    chk1("wr_rsp_valid", bus_if.rsp_valid_o, 1'b1);
    chk1("wr_cyc_drop", bus_if.wbm_cyc_o, 1'b0);
    chk32("wr_rsp_dat", bus_if.rsp_dat_o, 32'h0);
    chk1("wr_rsp_err", bus_if.rsp_err_o, 1'b0);
    bus_if.rsp_ready_i = 1'b1;
    tick();
    bus_if.rsp_ready_i = 1'b0;
    chk1("wr_idle_ready", bus_if.cmd_ready_o, 1'b1);
    chk1("wr_idle_valid", bus_if.rsp_valid_o, 1'b0);

    // Read, ack in first stb cycle
    cmd(1'b0, 32'h08, 32'hFFFF_FFFF);
    tick();
    bus_if.cmd_valid_i = 1'b0;
    chk1("rd_we", bus_if.wbm_we_o, 1'b0);
    chk32("rd_adr", bus_if.wbm_adr_o, 32'h08);
    bus_if.wbm_ack_i = 1'b1;
    bus_if.wbm_dat_i = 32'h1234_5678;
    tick();
    bus_if.wbm_ack_i = 1'b0;
    chk1("rd_rsp_valid", bus_if.rsp_valid_o, 1'b1);
    chk32("rd_rsp_dat", bus_if.rsp_dat_o, 32'h1234_5678);
    chk1("rd_rsp_err", bus_if.rsp_err_o, 1'b0);
    bus_if.rsp_ready_i = 1'b1;
    tick();
    bus_if.rsp_ready_i = 1'b0;

    // Timeout: slave never acks
    cmd(1'b0, 32'h10, 32'h0);
    tick();
    bus_if.cmd_valid_i = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && bus_if.wbm_cyc_o; i++) begin
      n++;
      tick();
    end
    chk32("to_cyc_cycles", 32'(n), 32'd16);
    chk1("to_rsp_valid", bus_if.rsp_valid_o, 1'b1);
    chk1("to_rsp_err", bus_if.rsp_err_o, 1'b1);
    chk32("to_rsp_dat", bus_if.rsp_dat_o, 32'h0);
    bus_if.wbm_ack_i = 1'b1;
    bus_if.wbm_dat_i = 32'hFFFF_0000;
    tick();
    bus_if.wbm_ack_i = 1'b0;
    chk1("late_ack_valid", bus_if.rsp_valid_o, 1'b1);
    chk1("late_ack_err", bus_if.rsp_err_o, 1'b1);
    chk32("late_ack_dat", bus_if.rsp_dat_o, 32'h0);
    bus_if.rsp_ready_i = 1'b1;
    tick();
    bus_if.rsp_ready_i = 1'b0;
    bus_if.wbm_ack_i = 1'b1;
    tick();
    bus_if.wbm_ack_i = 1'b0;
    chk1("idle_ack_ready", bus_if.cmd_ready_o, 1'b1);
    chk1("idle_ack_cyc", bus_if.wbm_cyc_o, 1'b0);
    chk1("idle_ack_valid", bus_if.rsp_valid_o, 1'b0);

    // Backpressure with a second command waiting
    cmd(1'b1, 32'h20, 32'h1111_2222);
    tick();
    cmd(1'b1, 32'h24, 32'h3333_4444);
    bus_if.wbm_ack_i = 1'b1;
    tick();
    bus_if.wbm_ack_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk32("bp_stable",
            {bus_if.rsp_dat_o[27:0], bus_if.rsp_valid_o, bus_if.cmd_ready_o, bus_if.wbm_cyc_o, bus_if.rsp_err_o},
            {28'h0, 1'b1, 1'b0, 1'b0, 1'b0});
      tick();
    end
    bus_if.rsp_ready_i = 1'b1;
    tick();
    bus_if.rsp_ready_i = 1'b0;
    chk1("bp_release_ready", bus_if.cmd_ready_o, 1'b1);
    tick();
    bus_if.cmd_valid_i = 1'b0;
    chk1("bp_second_cyc", bus_if.wbm_cyc_o, 1'b1);
    chk32("bp_second_adr", bus_if.wbm_adr_o, 32'h24);
    chk32("bp_second_dat", bus_if.wbm_dat_o, 32'h3333_4444);
    bus_if.wbm_ack_i = 1'b1;
    tick();
    bus_if.wbm_ack_i = 1'b0;
    chk1("bp_second_rsp", bus_if.rsp_valid_o, 1'b1);
    bus_if.rsp_ready_i = 1'b1;
    tick();
    bus_if.rsp_ready_i = 1'b0;

    // Reset asserted mid bus cycle
    cmd(1'b0, 32'h30, 32'h0);
    tick();
    bus_if.cmd_valid_i = 1'b0;
    chk1("rm_cyc_before", bus_if.wbm_cyc_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("rm_cyc_async", bus_if.wbm_cyc_o, 1'b0);
    chk1("rm_stb_async", bus_if.wbm_stb_o, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk1("rm_no_rsp", bus_if.rsp_valid_o, 1'b0);
    chk1("rm_ready", bus_if.cmd_ready_o, 1'b1);
    cmd(1'b0, 32'h34, 32'h0);
    tick();
    bus_if.cmd_valid_i = 1'b0;
    bus_if.wbm_ack_i = 1'b1;
    bus_if.wbm_dat_i = 32'hCAFE_F00D;
    tick();
    bus_if.wbm_ack_i = 1'b0;
    chk1("rm_next_valid", bus_if.rsp_valid_o, 1'b1);
    chk32("rm_next_dat", bus_if.rsp_dat_o, 32'hCAFE_F00D);
    chk1("rm_next_err", bus_if.rsp_err_o, 1'b0);
    bus_if.rsp_ready_i = 1'b1;
    tick();
    bus_if.rsp_ready_i = 1'b0;

    // Ack in the 16th (last) bus cycle wins over timeout
    cmd(1'b0, 32'h40, 32'h0);
    tick();
    bus_if.cmd_valid_i = 1'b0;
    repeat (15) tick();
    chk1("edge_cyc_16", bus_if.wbm_cyc_o, 1'b1);
    bus_if.wbm_ack_i = 1'b1;
    bus_if.wbm_dat_i = 32'h0BAD_C0DE;
    tick();
    bus_if.wbm_ack_i = 1'b0;
    chk1("edge_rsp_valid", bus_if.rsp_valid_o, 1'b1);
    chk1("edge_rsp_err", bus_if.rsp_err_o, 1'b0);
    chk32("edge_rsp_dat", bus_if.rsp_dat_o, 32'h0BAD_C0DE);
    bus_if.rsp_ready_i = 1'b1;
    tick();
    bus_if.rsp_ready_i = 1'b0;
    chk1("edge_idle", bus_if.cmd_ready_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
